alu_share_arbiter: RTL and testbench

//  Shares the single RV151 ALU (4-bit alu_op, two 32-bit operands, combinational alu_out) between
//  NUM_REQ requesters (e.g. pipeline EX stage and an address-gen/CSR helper). Arbitrates

---
 rtl/alu_share_arbiter.sv | 155 +++++++++++++++
 tb/tb_alu_share_arbiter.sv | 299 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_share_arbiter.sv
// Shares one combinational ALU between NUM_REQ requesters: round-robin grant, one EXEC cycle,
// registered tagged response. Define ALU_ARB_FIXED_PRIO_EN for fixed lowest-index-wins priority.
module alu_share_arbiter #(
    parameter int unsigned NUM_REQ = 2,
    parameter int unsigned ID_W    = 2
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [NUM_REQ-1:0]      req_valid,
    output logic [NUM_REQ-1:0]      req_ready,
    input  logic [4*NUM_REQ-1:0]    req_op,
    input  logic [32*NUM_REQ-1:0]   req_in1,
    input  logic [32*NUM_REQ-1:0]   req_in2,
    output logic                    rsp_valid,
    input  logic                    rsp_ready,
    output logic [ID_W-1:0]         rsp_id,
    output logic [31:0]             rsp_data,
    output logic [3:0]              alu_op,
    output logic [31:0]             alu_in1,
    output logic [31:0]             alu_in2,
    input  logic [31:0]             alu_out
);

    typedef enum logic [1:0] {StIdle, StExec, StResp} state_e;

    state_e            state_q, state_d;
    logic [ID_W-1:0]   last_grant_q, last_grant_d;
    logic [3:0]        op_q, op_d;
    logic [31:0]       in1_q, in1_d;
    logic [31:0]       in2_q, in2_d;
    logic [ID_W-1:0]   id_q, id_d;
    logic              rsp_valid_q, rsp_valid_d;
    logic [ID_W-1:0]   rsp_id_q, rsp_id_d;
    logic [31:0]       rsp_data_q, rsp_data_d;

    logic              arb_en;
    logic              gnt_found;
    logic [ID_W-1:0]   gnt_idx;
    logic              req_hs;
    logic [3:0]        sel_op;
    logic [31:0]       sel_in1;
    logic [31:0]       sel_in2;

    // Arbitration runs in IDLE, or in RESP in the cycle the response is consumed.
    assign arb_en = (state_q == StIdle) || ((state_q == StResp) && rsp_ready);

    always_comb begin
        gnt_found = 1'b0;
        gnt_idx   = '0;
`ifdef ALU_ARB_FIXED_PRIO_EN
        for (int i = int'(NUM_REQ) - 1; i >= 0; i--) begin
            if (req_valid[i]) begin
                gnt_found = 1'b1;
                gnt_idx   = ID_W'(i);
            end
        end
`else
        // Scan backwards so the candidate closest after last_grant is assigned last and wins.
        for (int k = int'(NUM_REQ); k >= 1; k--) begin
            if (req_valid[(int'(last_grant_q) + k) % int'(NUM_REQ)]) begin
                gnt_found = 1'b1;
                gnt_idx   = ID_W'((int'(last_grant_q) + k) % int'(NUM_REQ));
            end
        end
`endif
    end

    assign req_hs = arb_en && gnt_found;

    always_comb begin
        req_ready = '0;
        sel_op    = '0;
        sel_in1   = '0;
        sel_in2   = '0;
        for (int i = 0; i < int'(NUM_REQ); i++) begin
            if (gnt_idx == ID_W'(i)) begin
                req_ready[i] = req_hs && rst_n;
                sel_op       = req_op[4*i +: 4];
                sel_in1      = req_in1[32*i +: 32];
                sel_in2      = req_in2[32*i +: 32];
            end
        end
    end

    always_comb begin
        state_d      = state_q;
        last_grant_d = last_grant_q;
        op_d         = op_q;
        in1_d        = in1_q;
        in2_d        = in2_q;
        id_d         = id_q;
        rsp_valid_d  = rsp_valid_q;
        rsp_id_d     = rsp_id_q;
        rsp_data_d   = rsp_data_q;

        unique case (state_q)
            StIdle: begin
                if (req_hs) state_d = StExec;
            end
            StExec: begin
                rsp_data_d  = alu_out;
                rsp_id_d    = id_q;
                rsp_valid_d = 1'b1;
                state_d     = StResp;
            end
            StResp: begin
                if (rsp_ready) begin
                    rsp_valid_d = 1'b0;
                    state_d     = req_hs ? StExec : StIdle;
                end
            end
            default: state_d = StIdle;
        endcase

        if (req_hs) begin
            op_d         = sel_op;
            in1_d        = sel_in1;
            in2_d        = sel_in2;
            id_d         = gnt_idx;
            last_grant_d = gnt_idx;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= StIdle;
            last_grant_q <= ID_W'(NUM_REQ - 1);
            op_q         <= '0;
            in1_q        <= '0;
            in2_q        <= '0;
            id_q         <= '0;
            rsp_valid_q  <= 1'b0;
            rsp_id_q     <= '0;
            rsp_data_q   <= '0;
        end else begin
            state_q      <= state_d;
            last_grant_q <= last_grant_d;
            op_q         <= op_d;
            in1_q        <= in1_d;
            in2_q        <= in2_d;
            id_q         <= id_d;
            rsp_valid_q  <= rsp_valid_d;
            rsp_id_q     <= rsp_id_d;
            rsp_data_q   <= rsp_data_d;
        end
    end

    assign rsp_valid = rsp_valid_q;
    assign rsp_id    = rsp_id_q;
    assign rsp_data  = rsp_data_q;
    assign alu_op    = op_q;
    assign alu_in1   = in1_q;
    assign alu_in2   = in2_q;

endmodule

// File: tb/tb_alu_share_arbiter.sv
// Randomized and directed bench for alu_share_arbiter with a transaction-level reference model
// and a behavioural ALU; honours ALU_ARB_FIXED_PRIO_EN.
module tb_alu_share_arbiter;

    localparam int NR = 3;
    localparam int IW = 2;

    logic              clk = 1'b0;
    logic              rst_n;
    logic [NR-1:0]     req_valid;
    logic [NR-1:0]     req_ready;
    logic [4*NR-1:0]   req_op;
    logic [32*NR-1:0]  req_in1;
    logic [32*NR-1:0]  req_in2;
    logic              rsp_valid;
    logic              rsp_ready;
    logic [IW-1:0]     rsp_id;
    logic [31:0]       rsp_data;
    logic [3:0]        alu_op;
    logic [31:0]       alu_in1;
    logic [31:0]       alu_in2;
    logic [31:0]       alu_out;

    int n_tests = 0;
    int n_fail  = 0;

    // Reference model state, transaction level
    int          m_last;
    bit          m_exec;
    bit          m_rv;
    int          m_id, p_id;
    logic [31:0] m_data, p_data;
    int          obs_gnt;
    int          gq[$];
    int          rid_q[$];
    logic [31:0] rdat_q[$];

    always #5 clk = ~clk;

    function automatic logic [31:0] alu_ref(logic [3:0] op, logic [31:0] a, logic [31:0] b);
        case (op)
            4'd0: return a + b;
            4'd1: return a - b;
            4'd2: return a << b[4:0];
            4'd3: return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
            4'd4: return (a < b) ? 32'd1 : 32'd0;
            4'd5: return a ^ b;
            4'd6: return a >> b[4:0];
            4'd7: return $signed(a) >>> b[4:0];
            4'd8: return a | b;
            4'd9: return a & b;
            default: return 32'd0;
        endcase
    endfunction

    assign alu_out = alu_ref(alu_op, alu_in1, alu_in2);

    alu_share_arbiter #(.NUM_REQ(NR), .ID_W(IW)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_op    (req_op),
        .req_in1   (req_in1),
        .req_in2   (req_in2),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_id    (rsp_id),
        .rsp_data  (rsp_data),
        .alu_op    (alu_op),
        .alu_in1   (alu_in1),
        .alu_in2   (alu_in2),
        .alu_out   (alu_out)
    );

    task automatic check_eq(string tag, logic [31:0] act, logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %08h expected %08h at %0t", tag, act, exp, $time);
        end
    endtask

    function automatic int pick(logic [NR-1:0] v, int last);
`ifdef ALU_ARB_FIXED_PRIO_EN
        for (int i = 0; i < NR; i++) if (v[i]) return i;
`else
        for (int k = 1; k <= NR; k++) if (v[(last + k) % NR]) return (last + k) % NR;
`endif
        return -1;
    endfunction

    task automatic model_reset();
        m_last = NR - 1;
        m_exec = 0;
        m_rv   = 0;
        m_id   = 0;
        m_data = '0;
    endtask

    // Compare DUT against model for the current cycle, then advance model over the next edge.
    task automatic check_cycle();
        int          g;
        logic [31:0] exp_rdy;
        g = (!m_exec && (!m_rv || rsp_ready)) ? pick(req_valid, m_last) : -1;
        exp_rdy = (g >= 0) ? (32'd1 << g) : 32'd0;
        obs_gnt = -1;
        for (int i = 0; i < NR; i++) if (req_ready[i]) obs_gnt = i;
        if (rsp_valid && rsp_ready) begin
            rid_q.push_back(int'(rsp_id));
            rdat_q.push_back(rsp_data);
        end
        check_eq("req_ready", 32'(req_ready), exp_rdy);
        check_eq("rsp_valid", 32'(rsp_valid), 32'(m_rv));
        if (m_rv) begin
            check_eq("rsp_id", 32'(rsp_id), 32'(m_id));
            check_eq("rsp_data", rsp_data, m_data);
        end
        if (m_exec) begin
            m_rv   = 1;
            m_id   = p_id;
            m_data = p_data;
            m_exec = 0;
        end else if (m_rv && rsp_ready) begin
            m_rv = 0;
        end
        if (g >= 0) begin
            p_id   = g;
            p_data = alu_ref(req_op[4*g +: 4], req_in1[32*g +: 32], req_in2[32*g +: 32]);
            m_last = g;
            m_exec = 1;
        end
    endtask

    task automatic tick();
        #1 check_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic set_req(int id, logic [3:0] op, logic [31:0] a, logic [31:0] b);
        req_op[4*id +: 4]    = op;
        req_in1[32*id +: 32] = a;
        req_in2[32*id +: 32] = b;
    endtask

    task automatic drain();
        req_valid = '0;
        rsp_ready = 1'b1;
        for (int i = 0; i < 4; i++) tick();
    endtask

    task automatic run_single(string tag, int id, logic [3:0] op, logic [31:0] a,
                              logic [31:0] b, logic [31:0] exp);
        int n;
        drain();
        set_req(id, op, a, b);
        req_valid = '0;
        req_valid[id] = 1'b1;
        tick();
        req_valid = '0;
        n = 0;
        while (!rsp_valid && n < 10) begin
            tick();
            n++;
        end
        check_eq({tag, "_lat"}, n, 1);
        check_eq({tag, "_data"}, rsp_data, exp);
        check_eq({tag, "_id"}, 32'(rsp_id), id);
        tick();
    endtask

    initial begin
        int exp_g[4];
        int n;
`ifdef ALU_ARB_FIXED_PRIO_EN
        exp_g = '{0, 0, 0, 0};
`else
        exp_g = '{0, 1, 2, 0};
`endif
        rst_n     = 1'b0;
        req_valid = '1;
        rsp_ready = 1'b1;
        req_op    = '0;
        req_in1   = '0;
        req_in2   = '0;
        model_reset();
        #12;
        check_eq("rst_req_ready", 32'(req_ready), 0);
        check_eq("rst_rsp_valid", 32'(rsp_valid), 0);
        check_eq("rst_rsp_id", 32'(rsp_id), 0);
        check_eq("rst_rsp_data", rsp_data, 0);
        check_eq("rst_alu_op", 32'(alu_op), 0);
        check_eq("rst_alu_in", alu_in1 | alu_in2, 0);
        @(posedge clk);
        #1;
        req_valid = '0;
        rst_n = 1'b1;

        // Directed single operations
        run_single("add", 0, 4'd0, 32'd5, 32'd7, 32'd12);
        run_single("slt", 1, 4'd3, 32'hFFFF_FFFF, 32'd1, 32'd1);
        run_single("sltu", 2, 4'd4, 32'hFFFF_FFFF, 32'd1, 32'd0);
        run_single("sll", 0, 4'd2, 32'd1, 32'd33, 32'd2);
        run_single("opF", 1, 4'hF, 32'h1234_5678, 32'd9, 32'd0);
        run_single("sra", 2, 4'd7, 32'h8000_0000, 32'd4, 32'hF800_0000);

        // Backpressure: response held, pending requester accepted on release
        drain();
        set_req(0, 4'd0, 32'd20, 32'd22);
        set_req(1, 4'd1, 32'd100, 32'd1);
        req_valid = 3'b001;
        rsp_ready = 1'b0;
        tick();
        req_valid = '0;
        tick();
        req_valid = 3'b010;
        for (int i = 0; i < 5; i++) begin
            #1;
            check_eq("bp_data", rsp_data, 32'd42);
            check_eq("bp_ready", 32'(req_ready), 0);
            tick();
        end
        rsp_ready = 1'b1;
        #1;
        check_eq("bp_release_ready", 32'(req_ready), 32'b010);
        tick();
        req_valid = '0;
        check_eq("bp_exec_valid", 32'(rsp_valid), 0);
        tick();
        check_eq("bp_rsp_valid", 32'(rsp_valid), 1);
        check_eq("bp_rsp_data", rsp_data, 32'd99);
        check_eq("bp_rsp_id", 32'(rsp_id), 1);

        // Random traffic against the model
        for (int c = 0; c < 3000; c++) begin
            req_valid = NR'($urandom);
            rsp_ready = ($urandom_range(0, 3) != 0);
            for (int i = 0; i < NR; i++) begin
                set_req(i, 4'($urandom_range(0, 15)), $urandom,
                        ($urandom_range(0, 1) != 0) ? 32'($urandom_range(0, 40)) : $urandom);
            end
            tick();
        end

        // Reset during EXEC drops the in-flight op
        drain();
        set_req(0, 4'd0, 32'd1, 32'd1);
        req_valid = 3'b001;
        tick();
        req_valid = '1;
        rst_n = 1'b0;
        #1;
        check_eq("rst_exec_valid", 32'(rsp_valid), 0);
        check_eq("rst_exec_ready", 32'(req_ready), 0);
        @(posedge clk);
        #1;
        check_eq("rst_hold_valid", 32'(rsp_valid), 0);
        rst_n = 1'b1;
        model_reset();
        req_valid = '0;
        tick();
        check_eq("rst_no_rsp", 32'(rsp_valid), 0);

        // Fairness with all requesters valid
        set_req(0, 4'd1, 32'd10, 32'd3);
        set_req(1, 4'd7, 32'h8000_0000, 32'd4);
        set_req(2, 4'd0, 32'd1, 32'd2);
        gq.delete();
        rid_q.delete();
        rdat_q.delete();
        req_valid = '1;
        rsp_ready = 1'b1;
        n = 0;
        while (gq.size() < 4 && n < 20) begin
            tick();
            if (obs_gnt >= 0) gq.push_back(obs_gnt);
            n++;
        end
        check_eq("gnt_count", gq.size(), 4);
        for (int i = 0; i < 4; i++) begin
            check_eq($sformatf("gnt%0d", i), (i < gq.size()) ? gq[i] : 32'hDEAD, exp_g[i]);
        end
        check_eq("rsp0_id", (rid_q.size() > 0) ? rid_q[0] : 32'hDEAD, 0);
        check_eq("rsp0_data", (rdat_q.size() > 0) ? rdat_q[0] : 32'hDEAD, 32'd7);
`ifdef ALU_ARB_FIXED_PRIO_EN
        check_eq("rsp1_id", (rid_q.size() > 1) ? rid_q[1] : 32'hDEAD, 0);
        check_eq("rsp1_data", (rdat_q.size() > 1) ? rdat_q[1] : 32'hDEAD, 32'd7);
`else
        check_eq("rsp1_id", (rid_q.size() > 1) ? rid_q[1] : 32'hDEAD, 1);
        check_eq("rsp1_data", (rdat_q.size() > 1) ? rdat_q[1] : 32'hDEAD, 32'hF800_0000);
`endif
        drain();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
